// File: rtl/zm_poly_synth.sv
`timescale 1ns/1ps
// zm_poly_synth
// -------------
// Polyphonic saw-voice engine. It holds VOICES independent voices. Each voice
// has a phase accumulator, a pitch, a gate and a 16-bit envelope.
// Note-on/note-off commands allocate and release voices. On every sample_tick,
// the engine walks each voice through one shared multiply/accumulate path, one
// voice per cycle. It then emits one mixed, signed sample.
//
// Optional feature: define ZM_POLY_DETUNE_EN to add a second, slightly sharp
// accumulator per voice. The two saws are averaged. Latency does not change.
//
// Ports:
//   clk          system clock, the only clock
//   rst          synchronous active-high reset
//   sample_tick  one-cycle strobe at the sample rate; honoured only when idle
//   cmd_valid    a command is present
//   cmd_ready    command accepted when cmd_valid & cmd_ready
//   cmd_on       1 = note-on, 0 = note-off
//   cmd_pitch    phase increment per sample, also used as the note identity
//   decay_time   envelope decrement per sample after release (0 = hold)
//   audio_out    signed mixed sample, held between frames
//   audio_valid  one-cycle strobe when audio_out is updated
//   active_mask  bit v set while voice v has a non-zero envelope
module zm_poly_synth #(
  parameter int VOICES = 4,
  parameter int W      = 16,
  parameter int PW     = 16,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_on,
  input  logic [PW-1:0]     cmd_pitch,
  input  logic [15:0]       decay_time,
  output logic [W-1:0]      audio_out,
  output logic              audio_valid,
  output logic [VOICES-1:0] active_mask
);

  localparam int VI_W  = $clog2(VOICES);
  localparam int SUM_W = W + VI_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PROC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [VI_W-1:0]         vidx_q, vidx_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [VI_W-1:0]         steal_ptr_q, steal_ptr_d;
  logic [W-1:0]            audio_out_q, audio_out_d;
  logic                    audio_valid_q, audio_valid_d;
  logic [VOICES-1:0]       active_mask_q, active_mask_d;

  logic [ACC_W-1:0]        phase_q [VOICES];
  logic [ACC_W-1:0]        phase_d [VOICES];
  logic [PW-1:0]           pitch_q [VOICES];
  logic [PW-1:0]           pitch_d [VOICES];
  logic [15:0]             env_q   [VOICES];
  logic [15:0]             env_d   [VOICES];
  logic [VOICES-1:0]       gate_q, gate_d;

`ifdef ZM_POLY_DETUNE_EN
  logic [ACC_W-1:0]        phase2_q [VOICES];
  logic [ACC_W-1:0]        phase2_d [VOICES];
  logic [ACC_W-1:0]        cur_phase2;
  logic signed [W-1:0]     saw2;
`endif

  logic                    cmd_fire;
  logic                    hit_found, free_found;
  logic [VI_W-1:0]         hit_idx, free_idx, tgt_idx;

  logic [ACC_W-1:0]        cur_phase;
  logic [15:0]             cur_env;
  logic signed [W-1:0]     saw1, saw;
  logic signed [W+16:0]    saw_ext, env_ext, prod_full;
  logic signed [W-1:0]     prod;
  logic signed [SUM_W-1:0] sum_shr;
  logic                    unused_ok;

  assign cmd_ready   = (state_q == ST_IDLE) & ~sample_tick & ~rst;
  assign cmd_fire    = cmd_valid & cmd_ready;
  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign active_mask = active_mask_q;

  // Voice search for note-on: scan from the top index down so that the
  // lowest-index match and the lowest-index free voice win.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if ((env_q[i] != 16'd0) && (pitch_q[i] == cmd_pitch)) begin
        hit_found = 1'b1;
        hit_idx   = VI_W'(i);
      end
      if (env_q[i] == 16'd0) begin
        free_found = 1'b1;
        free_idx   = VI_W'(i);
      end
    end
  end

  // Shared per-voice datapath for the voice selected by vidx_q. The saw and
  // the gain use the freshly advanced phase and the freshly decayed envelope.
  always_comb begin
    cur_phase = phase_q[vidx_q] + ACC_W'(pitch_q[vidx_q]);
    if (gate_q[vidx_q]) begin
      cur_env = env_q[vidx_q];
    end else if (env_q[vidx_q] > decay_time) begin
      cur_env = env_q[vidx_q] - decay_time;
    end else begin
      cur_env = 16'd0;
    end
    saw1 = cur_phase[ACC_W-1 -: W];
`ifdef ZM_POLY_DETUNE_EN
    cur_phase2 = phase2_q[vidx_q] + ACC_W'(pitch_q[vidx_q])
               + ACC_W'(pitch_q[vidx_q] >> 7);
    saw2 = cur_phase2[ACC_W-1 -: W];
    saw  = (saw1 >>> 1) + (saw2 >>> 1);
`else
    saw  = saw1;
`endif
    // The envelope is treated as an unsigned gain in [0, 1). A free voice has
    // env = 0, so it contributes nothing without any special case.
    saw_ext   = {{17{saw[W-1]}}, saw};
    env_ext   = {{(W+1){1'b0}}, cur_env};
    prod_full = saw_ext * env_ext;
    prod      = prod_full[W+15:16];
    sum_shr   = sum_q >>> VI_W;
  end

  assign unused_ok = ^{prod_full[W+16], prod_full[15:0], sum_shr[SUM_W-1:W]};

  // Frame sequencing and command execution. A tick in IDLE starts a frame.
  // Commands are only taken in IDLE, when no tick is present.
  always_comb begin
    state_d       = state_q;
    vidx_d        = vidx_q;
    sum_d         = sum_q;
    steal_ptr_d   = steal_ptr_q;
    audio_out_d   = audio_out_q;
    audio_valid_d = 1'b0;
    phase_d       = phase_q;
    pitch_d       = pitch_q;
    env_d         = env_q;
    gate_d        = gate_q;
    tgt_idx       = steal_ptr_q;
`ifdef ZM_POLY_DETUNE_EN
    phase2_d      = phase2_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_PROC;
          vidx_d  = '0;
          sum_d   = '0;
        end else if (cmd_fire) begin
          if (cmd_on) begin
            if (hit_found) begin
              tgt_idx = hit_idx;
            end else if (free_found) begin
              tgt_idx = free_idx;
            end else begin
              tgt_idx     = steal_ptr_q;
              steal_ptr_d = steal_ptr_q + 1'b1;
            end
            pitch_d[tgt_idx] = cmd_pitch;
            phase_d[tgt_idx] = '0;
            gate_d[tgt_idx]  = 1'b1;
            env_d[tgt_idx]   = 16'hFFFF;
`ifdef ZM_POLY_DETUNE_EN
            phase2_d[tgt_idx] = '0;
`endif
          end else begin
            for (int i = 0; i < VOICES; i++) begin
              if ((env_q[i] != 16'd0) && (pitch_q[i] == cmd_pitch)) begin
                gate_d[i] = 1'b0;
              end
            end
          end
        end
      end
      ST_PROC: begin
        phase_d[vidx_q] = cur_phase;
        env_d[vidx_q]   = cur_env;
`ifdef ZM_POLY_DETUNE_EN
        phase2_d[vidx_q] = cur_phase2;
`endif
        sum_d = sum_q + {{VI_W{prod[W-1]}}, prod};
        if (vidx_q == VI_W'(VOICES - 1)) begin
          state_d = ST_OUT;
        end else begin
          vidx_d = vidx_q + 1'b1;
        end
      end
      ST_OUT: begin
        // Shifting the sum back down by log2(VOICES) always fits in W bits.
        audio_out_d   = sum_shr[W-1:0];
        audio_valid_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int i = 0; i < VOICES; i++) begin
      active_mask_d[i] = (env_d[i] != 16'd0);
    end
  end

  // State registers. Reset clears every voice and aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      vidx_q        <= '0;
      sum_q         <= '0;
      steal_ptr_q   <= '0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      active_mask_q <= '0;
      gate_q        <= '0;
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
        pitch_q[i] <= '0;
        env_q[i]   <= '0;
`ifdef ZM_POLY_DETUNE_EN
        phase2_q[i] <= '0;
`endif
      end
    end else begin
      state_q       <= state_d;
      vidx_q        <= vidx_d;
      sum_q         <= sum_d;
      steal_ptr_q   <= steal_ptr_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      active_mask_q <= active_mask_d;
      gate_q        <= gate_d;
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= phase_d[i];
        pitch_q[i] <= pitch_d[i];
        env_q[i]   <= env_d[i];
`ifdef ZM_POLY_DETUNE_EN
        phase2_q[i] <= phase2_d[i];
`endif
      end
    end
  end

endmodule

// File: doc/zm_poly_synth.md
# zm_poly_synth

Polyphonic saw-voice engine, the parametrised successor to the single-voice saw/decay/VCA chain. It holds `VOICES` independent voices, each with a phase accumulator, gate and envelope. Voices are allocated from note-on/note-off commands, typically decoded from SPI by the top level. On every `sample_tick` it time-multiplexes all voices through one multiply/accumulate path and emits one mixed sample for the filter/DAC path.

## Interface
Parameters:
- `VOICES`, 4: voice count; power of two, 2..16.
- `W`, 16: audio sample width (signed).
- `PW`, 16: pitch/increment width.
- `ACC_W`, 24: phase accumulator width; ≥ `W` and ≥ `PW`.

Ports:
- `clk` in 1: system clock (clk48); the only clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_tick` in 1: one-cycle strobe at Fs (e.g. rising LRCK, synchronised).
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_on` in 1: 1 = note-on, 0 = note-off.
- `cmd_pitch` in `PW`: phase increment per sample; also the note identity.
- `decay_time` in 16: envelope decrement per sample after release; 0 = hold forever.
- `audio_out` out `W`: signed mixed sample.
- `audio_valid` out 1: one-cycle strobe, `audio_out` updated.
- `active_mask` out `VOICES`: bit v = voice v envelope ≠ 0.

## Operation
- Per-voice state: `phase[ACC_W]`, `pitch[PW]`, `gate`, `env[16]`. A voice is free when `env == 0`.
- FSM: IDLE → PROC (one voice per cycle, v = 0..VOICES-1) → OUT → IDLE.
- In IDLE, `sample_tick` starts a frame. `sample_tick` outside IDLE is dropped.
- PROC, voice v:
  - `phase += zero-extended pitch`, modulo 2^ACC_W.
  - If gate = 0, `env = (env > decay_time) ? env - decay_time : 0`. If gate = 1, env is unchanged.
  - `saw = phase[ACC_W-1 -: W]` as signed.
  - `prod = (saw * {1'b0, env}) >>> 16`, signed, truncated to `W`.
  - Accumulate `prod` into a `W + log2(VOICES)` bit sum.
  - Free voices still advance phase but contribute 0.
- OUT: `audio_out = sum >>> log2(VOICES)`. This cannot overflow; no saturation is needed. `audio_valid` pulses.
- Commands execute in one cycle, and only in IDLE.
- Note-on:
  - (a) If an active voice has an equal `pitch`, retrigger it.
  - (b) Otherwise, take the lowest-index free voice.
  - (c) Otherwise, steal voice `steal_ptr`, then `steal_ptr = (steal_ptr + 1) mod VOICES`.
  - In all cases: `pitch = cmd_pitch`, `phase = 0`, `gate = 1`, `env = 16'hFFFF`.
- Note-off: every active voice with an equal `pitch` gets `gate = 0`. No match means no effect.
- `cmd_pitch = 0` note-on is legal and produces a silent but active voice.
- Reset clears every voice, `steal_ptr = 0`, and state = IDLE.
- Reset values: `audio_out = 0`, `audio_valid = 0`, `cmd_ready = 0` while `rst` is high, `active_mask = 0`.
- Reset mid-frame aborts the frame; no `audio_valid` follows.

## Timing
- `cmd_ready = (state == IDLE) & ~sample_tick & ~rst`. When `sample_tick` and `cmd_valid` coincide, the tick wins and the command waits.
- Effects of a command are visible in `active_mask` on the next cycle.
- Latency: `sample_tick` sampled at cycle t → `audio_valid` high in cycle t+VOICES+2.
- `cmd_ready` is low from t through t+VOICES+1, and high again at t+VOICES+2.
- `audio_out` holds its value between frames.
- `sample_tick` period must be ≥ VOICES+3 cycles.
- `active_mask` is registered and reflects state after the last command or frame.

## Configuration
- `ZM_POLY_DETUNE_EN` defined:
  - Each voice gets a second accumulator `phase2`, incremented by `pitch + (pitch >> 7)`.
  - `phase2` resets to 0 together with `phase`.
  - `saw = (saw1 >>> 1) + (saw2 >>> 1)`.
  - Latency is unchanged; the extra add is in the same PROC cycle.
- Undefined: single accumulator per voice, `saw = saw1`, and no `phase2` registers are built.

## Test plan
All scenarios use default parameters and `ZM_POLY_DETUNE_EN` undefined.
- Reset with `rst` held 3 cycles → `audio_out = 0`, `audio_valid = 0`, `active_mask = 0`, `cmd_ready = 0`, then `cmd_ready = 1` in the first cycle after `rst` falls.
- Note-on pitch 0x1000, then one tick → `active_mask = 4'b0001`; `audio_valid` 6 cycles after the tick; `audio_out = 16'h0003`. Derivation: saw 0x0010 × 0xFFFF >>> 16 = 0x000F, then >>> 2.
- Note-ons with pitches 0x100, 0x200, 0x300, 0x400, 0x500 → mask `4'b1111`; voice 0 pitch becomes 0x500; a sixth note-on (0x600) steals voice 1.
- Note-on 0x200 then note-off 0x200, `decay_time = 16'h4000` → env 0xBFFF, 0x7FFF, 0x3FFF, 0; the mask bit clears after the 4th frame. Note-off 0x777 changes nothing.
- `cmd_valid` rises in the same cycle as `sample_tick` → `cmd_ready = 0` for 6 cycles; command accepted in cycle t+6.
- A repeat note-on of a sounding pitch → same voice retriggered (phase = 0, env = 0xFFFF); mask unchanged; `steal_ptr` unchanged.
